// File: rtl/fifo_buffer_if.sv
// fifo_buffer_if: handshake, data and status bundle between a producer and fifo_buffer
interface fifo_buffer_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3
);
  logic                    push;
  logic                    pop;
  logic [DATA_WIDTH-1:0]   data_in;
  logic [ADDRESS_WIDTH:0]  th_full;
  logic [ADDRESS_WIDTH:0]  th_empty;
  logic [DATA_WIDTH-1:0]   data_out;
  logic                    valid_out;
  logic [ADDRESS_WIDTH:0]  count;
  logic                    full;
  logic                    empty;
  logic                    almost_full;
  logic                    almost_empty;
  logic                    fifo_error;
  modport master (
    output push, pop, data_in, th_full, th_empty,
    input  data_out, valid_out, count, full, empty, almost_full, almost_empty, fifo_error
  );
  modport slave (
    input  push, pop, data_in, th_full, th_empty,
    output data_out, valid_out, count, full, empty, almost_full, almost_empty, fifo_error
  );
endinterface

// File: rtl/fifo_buffer.sv
// fifo_buffer: synchronous FIFO with registered pop data, valid strobe, occupancy flags and sticky overflow
module fifo_buffer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 3,
  parameter int BUFFER_DEPTH  = 8
) (
  input logic clk,
  input logic reset,
  fifo_buffer_if.slave bus
);
  localparam logic [ADDRESS_WIDTH:0] DEPTH = (ADDRESS_WIDTH+1)'(BUFFER_DEPTH);
  logic [DATA_WIDTH-1:0]    mem_q [BUFFER_DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
  logic                     valid_q, valid_d, err_q, err_d;
  logic                     wr_en, rd_en, full, empty;
  assign full  = count_q == DEPTH;
  assign empty = count_q == '0;
  // accept decisions and next-state; a pop frees a slot so a push is taken even when full
  always_comb begin
    wr_en      = bus.push && (!full || bus.pop);
    rd_en      = bus.pop && !empty;
    wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = (wr_en && !rd_en) ? count_q + 1'b1 : (rd_en && !wr_en) ? count_q - 1'b1 : count_q;
    data_out_d = rd_en ? mem_q[rd_ptr_q] : data_out_q;
    valid_d    = rd_en;
    err_d      = err_q || (bus.push && full && !bus.pop);
  end
  // storage array; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.data_in;
  end
  // control state, cleared asynchronously so a reset discards stored words at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end
  assign bus.data_out     = data_out_q;
  assign bus.valid_out    = valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = count_q >= bus.th_full;
  assign bus.almost_empty = count_q <= bus.th_empty;
  assign bus.fifo_error   = err_q;
endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: randomized and directed stimulus checked against a queue-based model of the FIFO
module tb_fifo_buffer;
  localparam int DW = 8, AW = 3, DEPTH = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data = '0;
  logic m_valid = 1'b0, m_err = 1'b0;
  int sent;
  logic p, q;

  fifo_buffer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus();
  fifo_buffer #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .BUFFER_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: a queue of stored words, last popped word, strobe and sticky error
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_data  <= '0;
      m_valid <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      if (bus.push && !bus.pop && mq.size() == DEPTH) m_err <= 1'b1;
      if (bus.pop && mq.size() > 0) begin
        m_valid <= 1'b1;
        m_data  <= mq.pop_front();
      end else m_valid <= 1'b0;
      if (bus.push && mq.size() < DEPTH) mq.push_back(bus.data_in);
    end
  end

  // compare every output with the model, away from the active edge
  always @(negedge clk) begin
    chk("count", 32'(bus.count), mq.size());
    chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("almost_full", 32'(bus.almost_full), 32'(mq.size() >= int'(bus.th_full)));
    chk("almost_empty", 32'(bus.almost_empty), 32'(mq.size() <= int'(bus.th_empty)));
    chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
    chk("data_out", 32'(bus.data_out), 32'(m_data));
    chk("fifo_error", 32'(bus.fifo_error), 32'(m_err));
  end

  task automatic step(input logic sp, input logic sq, input logic [DW-1:0] d);
    bus.push = sp;
    bus.pop = sq;
    bus.data_in = d;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0);
  endtask

  initial begin
    bus.push = 0;
    bus.pop = 0;
    bus.data_in = 0;
    bus.th_full = 4'd6;
    bus.th_empty = 4'd2;
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    chk("lit_reset_empty", 32'(bus.empty), 1);
    chk("lit_reset_full", 32'(bus.full), 0);
    chk("lit_reset_count", 32'(bus.count), 0);
    chk("lit_reset_aempty", 32'(bus.almost_empty), 1);
    chk("lit_reset_afull", 32'(bus.almost_full), 0);
    reset = 1'b1;
    step(0, 0, 0);
    // fill
    for (int i = 0; i < 8; i++) step(1, 0, 8'((i + 1) * 17));
    chk("lit_fill_full", 32'(bus.full), 1);
    chk("lit_fill_count", 32'(bus.count), 8);
    chk("lit_fill_afull", 32'(bus.almost_full), 1);
    // overflow
    step(1, 0, 8'hAA);
    chk("lit_ovf_err", 32'(bus.fifo_error), 1);
    chk("lit_ovf_count", 32'(bus.count), 8);
    // drain
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0);
      chk("lit_drain_data", 32'(bus.data_out), (i + 1) * 17);
      chk("lit_drain_valid", 32'(bus.valid_out), 1);
    end
    step(0, 0, 0);
    chk("lit_drain_valid_end", 32'(bus.valid_out), 0);
    chk("lit_drain_empty", 32'(bus.empty), 1);
    chk("lit_err_sticky", 32'(bus.fifo_error), 1);
    do_reset();
    chk("lit_err_cleared", 32'(bus.fifo_error), 0);
    // simultaneous push/pop while full
    for (int i = 0; i < 8; i++) step(1, 0, 8'((i + 1) * 17));
    step(1, 1, 8'hBB);
    chk("lit_fullpp_data", 32'(bus.data_out), 32'h11);
    chk("lit_fullpp_count", 32'(bus.count), 8);
    chk("lit_fullpp_err", 32'(bus.fifo_error), 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0);
    chk("lit_fullpp_last", 32'(bus.data_out), 32'hBB);
    // empty edge cases
    step(0, 1, 0);
    chk("lit_empty_pop_valid", 32'(bus.valid_out), 0);
    chk("lit_empty_pop_data", 32'(bus.data_out), 32'hBB);
    step(1, 1, 8'h5A);
    chk("lit_empty_pp_count", 32'(bus.count), 1);
    chk("lit_empty_pp_valid", 32'(bus.valid_out), 0);
    step(0, 1, 0);
    chk("lit_empty_pp_data", 32'(bus.data_out), 32'h5A);
    chk("lit_empty_pp_valid2", 32'(bus.valid_out), 1);
    // pointer wrap with occupancy held in 1..3
    step(1, 0, 8'($urandom));
    sent = 1;
    for (int k = 0; k < 300 && (sent < 20 || mq.size() > 0); k++) begin
      p = sent < 20 && mq.size() < 3 && $urandom_range(0, 1) == 1;
      q = (mq.size() > 1 || sent == 20) && $urandom_range(0, 1) == 1;
      if (p) sent++;
      step(p, q, 8'($urandom));
    end
    chk("lit_wrap_sent", sent, 20);
    // random stress, biased towards filling
    for (int k = 0; k < 400; k++) step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, 8'($urandom));
    do_reset();
    // reset in the middle of a burst
    step(1, 0, 8'h31);
    step(1, 0, 8'h32);
    step(1, 0, 8'h33);
    step(0, 1, 0);
    chk("lit_burst_valid", 32'(bus.valid_out), 1);
    chk("lit_burst_data", 32'(bus.data_out), 32'h31);
    #2 reset = 1'b0;
    #1;
    chk("lit_async_count", 32'(bus.count), 0);
    chk("lit_async_empty", 32'(bus.empty), 1);
    chk("lit_async_valid", 32'(bus.valid_out), 0);
    chk("lit_async_data", 32'(bus.data_out), 0);
    step(0, 0, 0);
    reset = 1'b1;
    step(0, 0, 0);
    step(0, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
